// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// MD opcode encoding, FSM state encoding and the iteration count.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MFHI  = 3'b100,
    MD_MFLO  = 3'b101,
    MD_MTHI  = 3'b110,
    MD_MTLO  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_FIX  = 2'b11
  } mdu_state_e;

  localparam int MDU_ITER = 32;

  // Magnitude of a 32-bit operand; only negated when the op is signed.
  function automatic logic [31:0] mdu_abs(input logic is_signed, input logic [31:0] x);
    return (is_signed && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath.
// mode_div_i=0: shift-add multiply step; accumulator holds
//   {partial product, remaining multiplier}.
// mode_div_i=1: restoring shift-subtract divide step; accumulator holds
//   {partial remainder, dividend/quotient bits}.
// Build option MDU_DIV_EN: when undefined the divide step is absent and a
// divide-mode request leaves the accumulator untouched.
module mdu_step (
  input  logic        mode_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
`ifdef MDU_DIV_EN
  logic [32:0] trial;
  logic [32:0] diff;
`endif

  // Single combinational iteration selected by mode.
  always_comb begin
    acc_o = acc_i;
    sum   = 33'd0;
`ifdef MDU_DIV_EN
    trial = acc_i[63:31];
    diff  = trial - {1'b0, opnd_i};
`endif
    if (!mode_div_i) begin
      sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
      acc_o = {sum, acc_i[31:1]};
    end
`ifdef MDU_DIV_EN
    else begin
      // Remainder is always below the divisor, so the shifted value fits in
      // 33 bits and the surviving remainder fits back into 32.
      if (trial >= {1'b0, opnd_i}) begin
        acc_o = {diff[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {trial[31:0], acc_i[30:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO, serving
// MFHI/MFLO/MTHI/MTLO and stalling the front end while busy.
// Build option MDU_DIV_EN enables DIV/DIVU; otherwise they are no-ops.
module ex_mdu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid_in,
  input  logic [2:0]  md_op_in,
  input  logic [31:0] RegRsData_in,
  input  logic [31:0] RegRtData_in,
  output logic        stall_out,
  output logic        busy_out,
  output logic [31:0] result_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [4:0] CNT_LAST = 5'(MDU_ITER - 1);

  mdu_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        neg_lo_q;   // product sign, or quotient sign
  logic        neg_hi_q;   // remainder sign
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef MDU_DIV_EN
  logic        is_div_q;
  logic        dz_q;
  logic [31:0] rs_q;
`endif

  md_op_e      op;
  logic        op_signed;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [63:0] acc_d;
  logic [63:0] prod_d;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  assign op        = md_op_e'(md_op_in);
  assign op_signed = ~md_op_in[0];
  assign rs_abs    = mdu_abs(op_signed, RegRsData_in);
  assign rt_abs    = mdu_abs(op_signed, RegRtData_in);

  mdu_step u_step (
    .mode_div_i (state_q == MDU_DIV),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (acc_d)
  );

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    prod_d = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    hi_d   = prod_d[63:32];
    lo_d   = prod_d[31:0];
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      lo_d = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
      hi_d = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      if (dz_q) begin
        lo_d = 32'hFFFF_FFFF;
        hi_d = rs_q;
      end
    end
`endif
  end

  // FSM, iteration counter, operand latches and architectural HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      rs_q     <= 32'd0;
`endif
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (md_valid_in) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                acc_q    <= {32'd0, rt_abs};
                opnd_q   <= rs_abs;
                neg_lo_q <= op_signed & (RegRsData_in[31] ^ RegRtData_in[31]);
                neg_hi_q <= 1'b0;
                cnt_q    <= 5'd0;
                state_q  <= MDU_MUL;
`ifdef MDU_DIV_EN
                is_div_q <= 1'b0;
                dz_q     <= 1'b0;
`endif
              end
`ifdef MDU_DIV_EN
              MD_DIV, MD_DIVU: begin
                acc_q    <= {32'd0, rs_abs};
                opnd_q   <= rt_abs;
                neg_lo_q <= op_signed & (RegRsData_in[31] ^ RegRtData_in[31]);
                neg_hi_q <= op_signed & RegRsData_in[31];
                is_div_q <= 1'b1;
                dz_q     <= (RegRtData_in == 32'd0);
                rs_q     <= RegRsData_in;
                cnt_q    <= 5'd0;
                state_q  <= MDU_DIV;
              end
`endif
              MD_MTHI: hi_q <= RegRsData_in;
              MD_MTLO: lo_q <= RegRsData_in;
              default: ;
            endcase
          end
        end
        MDU_MUL, MDU_DIV: begin
          acc_q <= acc_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= 5'd0;
            state_q <= MDU_FIX;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        MDU_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy_out  = (state_q != MDU_IDLE);
  assign stall_out = md_valid_in & busy_out;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

  // MFHI/MFLO read HI/LO combinationally while idle.
  always_comb begin
    result_out = 32'd0;
    if (md_valid_in && !busy_out) begin
      if (op == MD_MFHI) result_out = hi_q;
      else if (op == MD_MFLO) result_out = lo_q;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu with hand-computed expected values.
module tb_ex_mdu;

  logic        clk;
  logic        rst;
  logic        md_valid_in;
  logic [2:0]  md_op_in;
  logic [31:0] RegRsData_in;
  logic [31:0] RegRtData_in;
  logic        stall_out;
  logic        busy_out;
  logic [31:0] result_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp = 0;
  int n_err = 0;

  ex_mdu dut (
    .clk          (clk),
    .rst          (rst),
    .md_valid_in  (md_valid_in),
    .md_op_in     (md_op_in),
    .RegRsData_in (RegRsData_in),
    .RegRtData_in (RegRtData_in),
    .stall_out    (stall_out),
    .busy_out     (busy_out),
    .result_out   (result_out),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  // Present an op for one cycle, then count cycles with busy_out high.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    md_valid_in  = 1'b1;
    md_op_in     = op;
    RegRsData_in = a;
    RegRtData_in = b;
    #1;
    chk("launch_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    md_valid_in  = 1'b0;
    RegRsData_in = 32'd0;
    RegRtData_in = 32'd0;
    #1;
    busy_cycles = 0;
    while (busy_out && busy_cycles < 60) begin
      busy_cycles++;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int n;
    rst          = 1'b0;
    md_valid_in  = 1'b0;
    md_op_in     = 3'd0;
    RegRsData_in = 32'd0;
    RegRtData_in = 32'd0;
    #2;
    chk("rst_hi",    hi_out, 32'd0);
    chk("rst_lo",    lo_out, 32'd0);
    chk("rst_busy",  {31'd0, busy_out}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_res",   result_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // MULTU max*max
    launch(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_busy_cyc", 32'(n), 32'd33);
    chk("multu_hi", hi_out, 32'hFFFF_FFFE);
    chk("multu_lo", lo_out, 32'h0000_0001);

    // MULT -3 * 7 = -21
    @(posedge clk); #1;
    launch(3'b000, 32'hFFFF_FFFD, 32'd7, n);
    chk("mult_busy_cyc", 32'(n), 32'd33);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFEB);

`ifdef MDU_DIV_EN
    // DIV -7 / 2 = -3 rem -1
    @(posedge clk); #1;
    launch(3'b010, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_busy_cyc", 32'(n), 32'd33);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);
    // DIVU 7 / 0
    @(posedge clk); #1;
    launch(3'b011, 32'd7, 32'd0, n);
    chk("divz_busy_cyc", 32'(n), 32'd33);
    chk("divz_lo", lo_out, 32'hFFFF_FFFF);
    chk("divz_hi", hi_out, 32'd7);
    // DIV 0x80000000 / -1
    @(posedge clk); #1;
    launch(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divov_busy_cyc", 32'(n), 32'd33);
    chk("divov_lo", lo_out, 32'h8000_0000);
    chk("divov_hi", hi_out, 32'd0);
`else
    // DIVU 7 / 2 is a no-op without the divider
    @(posedge clk); #1;
    launch(3'b011, 32'd7, 32'd2, n);
    chk("nodiv_busy_cyc", 32'(n), 32'd0);
    chk("nodiv_hi", hi_out, 32'hFFFF_FFFF);
    chk("nodiv_lo", lo_out, 32'hFFFF_FFEB);
`endif

    // MULT 6*7 followed immediately by MFLO held by ID/EX
    @(posedge clk); #1;
    md_valid_in  = 1'b1;
    md_op_in     = 3'b000;
    RegRsData_in = 32'd6;
    RegRtData_in = 32'd7;
    @(posedge clk); #1;
    md_op_in     = 3'b101;
    RegRsData_in = 32'd0;
    RegRtData_in = 32'd0;
    #1;
    n = 0;
    while (stall_out && n < 60) begin
      n++;
      @(posedge clk); #2;
    end
    chk("mflo_stall_cyc", 32'(n), 32'd33);
    chk("mflo_result", result_out, 32'h0000_002A);
    chk("mflo_busy", {31'd0, busy_out}, 32'd0);
    @(posedge clk); #1;
    md_valid_in = 1'b0;

    // MULT launched, non-MD op alongside, reset pulsed mid-iteration
    md_valid_in  = 1'b1;
    md_op_in     = 3'b000;
    RegRsData_in = 32'd5;
    RegRtData_in = 32'd5;
    @(posedge clk); #1;
    md_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("add_busy", {31'd0, busy_out}, 32'd1);
    chk("add_stall", {31'd0, stall_out}, 32'd0);
    repeat (4) @(posedge clk);
    #2;
    md_valid_in = 1'b1;
    md_op_in    = 3'b101;
    #1;
    chk("pre_rst_stall", {31'd0, stall_out}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy_out}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_out}, 32'd0);
    chk("mid_rst_res",   result_out, 32'd0);
    chk("mid_rst_hi",    hi_out, 32'd0);
    chk("mid_rst_lo",    lo_out, 32'd0);
    md_valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // MTHI / MTLO / MFHI after reset
    @(posedge clk); #1;
    md_valid_in  = 1'b1;
    md_op_in     = 3'b110;
    RegRsData_in = 32'h0000_1234;
    #1;
    chk("mthi_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("mthi_hi", hi_out, 32'h0000_1234);
    chk("mthi_lo", lo_out, 32'd0);
    md_op_in     = 3'b111;
    RegRsData_in = 32'hCAFE_0055;
    @(posedge clk); #1;
    chk("mtlo_lo", lo_out, 32'hCAFE_0055);
    md_op_in = 3'b100;
    #1;
    chk("mfhi_result", result_out, 32'h0000_1234);
    md_valid_in = 1'b0;
    #1;
    chk("idle_result", result_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
